key_event_decoder: RTL and testbench
====================================

# key_event_decoder

Debounces the active-low `music_en` push button and classifies each gesture as a short press, double press or long press, emitting one-cycle event pulses. Sits directly upstream of the `present` music/light controller. It replaces raw button sampling there with clean, registered events: play/pause, next track and stop. All thresholds are in clock cycles, so benches can shrink them.

## Interface
- `DEBOUNCE_CYC`, default 100_000 (2 ms @ 50 MHz): cycles a new raw level must persist before it is accepted.
- `LONG_CYC`, default 2_500_000 (50 ms): press duration that qualifies as a long press.
- `DOUBLE_GAP_CYC`, default 750_000 (15 ms): maximum released gap between two presses that forms a double press.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-low reset.
- `key_n`  in  1  raw button, 0 = pressed; asynchronous to `clk`.
- `key_level`  out  1  debounced level, 1 = pressed.
- `short_press`  out  1  one-cycle pulse: single press that is neither long nor followed by a second press.
- `double_press`  out  1  one-cycle pulse: second press arrives within the gap window.
- `long_press`  out  1  one-cycle pulse: press has been held for `LONG_CYC`.
- `long_hold`  out  1  high from the `long_press` pulse until release.

## Operation
- Synchroniser: two flops on `key_n`, both reset to 1 (released).
- Debouncer:
  - Stable register `stable_n` resets to 1.
  - Counter `db_cnt` has width `$clog2(DEBOUNCE_CYC+1)` and resets to 0.
  - If the synchronised sample equals `stable_n`, `db_cnt` is set to 0.
  - Otherwise `db_cnt` increments. When it reaches `DEBOUNCE_CYC-1`, `stable_n` takes the sample and `db_cnt` is set to 0.
  - A glitch shorter than `DEBOUNCE_CYC` cycles never changes `stable_n`.
- `key_level = ~stable_n`, registered.
- Press edge = `stable_n` goes 1→0. Release edge = `stable_n` goes 0→1. Both are derived from a one-cycle-delayed copy of `stable_n`.
- Shared timer `tmr` has width `$clog2(max(LONG_CYC, DOUBLE_GAP_CYC)+1)`. It is cleared on every state change and increments otherwise.
- FSM states are IDLE, PRESS1, LONG, GAP and PRESS2. Reset state is IDLE.
  - IDLE: on a press edge, go to PRESS1.
  - PRESS1:
    - If `tmr == LONG_CYC-1` while still pressed, pulse `long_press` and go to LONG.
    - Else, on a release edge, go to GAP.
  - LONG: `long_hold = 1`. On a release edge, go to IDLE. No other event fires.
  - GAP:
    - On a press edge, pulse `double_press` and go to PRESS2.
    - Else, if `tmr == DOUBLE_GAP_CYC-1`, pulse `short_press` and go to IDLE.
    - If the press edge and the timeout fall in the same cycle, the press wins and only `double_press` fires.
  - PRESS2: on a release edge, go to IDLE. There is no long detection and no further event.
- A triple press produces one `double_press`. The third press starts a new gesture from IDLE.
- At most one of the three pulses is high in any cycle.
- Reset mid-gesture: all state returns to IDLE and all outputs go to 0 immediately. A button still held after reset release debounces to pressed and starts a fresh PRESS1.

## Timing
- Reset value of every output is 0. The synchroniser and `stable_n` reset to 1.
- Raw edge to `key_level` change takes 2 (sync) + `DEBOUNCE_CYC` + 1 cycles.
- Event pulses are registered. Each is high for exactly one cycle, on the cycle after the FSM condition is evaluated true. It coincides with the first cycle in the new state.
- Long-press latency: `long_press` asserts `LONG_CYC` + 1 cycles after the press edge cycle.
- Short-press latency: `short_press` asserts `DOUBLE_GAP_CYC` + 1 cycles after the release edge cycle.
- `long_hold` rises together with `long_press`. It falls on the cycle after the release edge.

## Test plan
Every scenario uses `DEBOUNCE_CYC`=4, `LONG_CYC`=20, `DOUBLE_GAP_CYC`=10.
- Reset: hold `rst`=0 with `key_n`=0. All outputs stay 0. Release reset; `key_level` rises 7 cycles later.
- Bounce: toggle `key_n` low for 3 cycles, then high, repeated 5 times. `key_level` stays 0 and no pulses fire.
- Short press: `key_n` low for 8 cycles, then high. There is exactly one `short_press`, 11 cycles after the debounced release edge. `double_press` and `long_press` stay 0.
- Double press: press 8 cycles, release 6 cycles, press 8 cycles. There is exactly one `double_press`, on the second debounced press, and no `short_press`.
- Long press: hold `key_n` low for 40 cycles. `long_press` pulses once, 21 cycles after the press edge. `long_hold` stays high until 1 cycle after the debounced release. There is no `short_press`.
- Reset mid-gesture: assert `rst` in GAP state. No `short_press` fires. After reset release, a new 8-cycle press yields a normal `short_press`.

Source files
------------

// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
// key_event_decoder : debounces an active-low button and classifies presses
//                     into short / double / long one-cycle event pulses.
// Revision: 1.0
// ============================================================================
module key_event_decoder #(
  parameter int DEBOUNCE_CYC   = 100_000,
  parameter int LONG_CYC       = 2_500_000,
  parameter int DOUBLE_GAP_CYC = 750_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic long_hold
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int MAX_CYC = (LONG_CYC > DOUBLE_GAP_CYC) ? LONG_CYC : DOUBLE_GAP_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [DB_W-1:0]  C_DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMR_W-1:0] C_LONG_LAST = TMR_W'(LONG_CYC - 1);
  localparam logic [TMR_W-1:0] C_GAP_LAST  = TMR_W'(DOUBLE_GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    LONG   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_n_q;
  logic             stable_n_d;
  logic             stable_dly_q;
  logic             key_level_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic [DB_W-1:0]  db_cnt_d;
  logic [TMR_W-1:0] tmr_q;
  state_t           state_q;
  logic             short_q;
  logic             double_q;
  logic             long_q;
  logic             long_hold_q;
  logic             w_press_edge;
  logic             w_release_edge;

  // The stable level only moves after DEBOUNCE_CYC consecutive disagreeing samples.
  always_comb begin
    stable_n_d = stable_n_q;
    db_cnt_d   = '0;
    if (sync2_q != stable_n_q) begin
      if (db_cnt_q == C_DB_LAST) begin
        stable_n_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_n_q   <= 1'b1;
      stable_dly_q <= 1'b1;
      db_cnt_q     <= '0;
      key_level_q  <= 1'b0;
    end else begin
      sync1_q      <= key_n;
      sync2_q      <= sync1_q;
      stable_n_q   <= stable_n_d;
      stable_dly_q <= stable_n_q;
      db_cnt_q     <= db_cnt_d;
      key_level_q  <= ~stable_n_q;
    end
  end

  assign w_press_edge   =  stable_dly_q & ~stable_n_q;
  assign w_release_edge = ~stable_dly_q &  stable_n_q;

  // Gesture classifier; the timer restarts on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      short_q     <= 1'b0;
      double_q    <= 1'b0;
      long_q      <= 1'b0;
      long_hold_q <= 1'b0;
    end else begin
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      tmr_q    <= tmr_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (w_press_edge) begin
            state_q <= PRESS1;
            tmr_q   <= '0;
          end
        end
        PRESS1: begin
          if (!stable_n_q && (tmr_q == C_LONG_LAST)) begin
            state_q     <= LONG;
            tmr_q       <= '0;
            long_q      <= 1'b1;
            long_hold_q <= 1'b1;
          end else if (w_release_edge) begin
            state_q <= GAP;
            tmr_q   <= '0;
          end
        end
        LONG: begin
          if (w_release_edge) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            long_hold_q <= 1'b0;
          end
        end
        GAP: begin
          // A press landing on the timeout cycle still counts as a double press.
          if (w_press_edge) begin
            state_q  <= PRESS2;
            tmr_q    <= '0;
            double_q <= 1'b1;
          end else if (tmr_q == C_GAP_LAST) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            short_q <= 1'b1;
          end
        end
        PRESS2: begin
          if (w_release_edge) begin
            state_q <= IDLE;
            tmr_q   <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          tmr_q       <= '0;
          long_hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign key_level    = key_level_q;
  assign short_press  = short_q;
  assign double_press = double_q;
  assign long_press   = long_q;
  assign long_hold    = long_hold_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================================
// tb_key_event_decoder : scoreboard bench for key_event_decoder.
// Revision: 1.0
// ============================================================================
module tb_key_event_decoder;

  localparam int DB = 4;
  localparam int LG = 20;
  localparam int GP = 10;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic key_n = 1'b0;
  logic key_level, short_press, double_press, long_press, long_hold;

  always #5 clk = ~clk;

  key_event_decoder #(
    .DEBOUNCE_CYC   (DB),
    .LONG_CYC       (LG),
    .DOUBLE_GAP_CYC (GP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_n        (key_n),
    .key_level    (key_level),
    .short_press  (short_press),
    .double_press (double_press),
    .long_press   (long_press),
    .long_hold    (long_hold)
  );

  // kind bits: {short, double, long}
  typedef struct {
    logic [2:0] kind;
    int         cyc;
  } ev_t;

  ev_t  sb[$];
  bit   hist[$];
  int   cyc;
  bit   m_pressed;
  int   ph;
  int   t_press;
  int   t_rel;
  logic exp_level;
  logic exp_hold;
  int   total = 0;
  int   bad   = 0;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_back(1'b1);
    cyc       = 0;
    m_pressed = 1'b0;
    ph        = 0;
    exp_level = 1'b0;
    exp_hold  = 1'b0;
    sb.delete();
  endtask

  // Behavioural model: hist[0] is the raw key at the current edge; the
  // debounced level flips once the DB samples two edges old and older all
  // disagree with it. Gestures are classified from edge timestamps.
  task automatic model_step();
    bit was_pressed, flip, pe, re;
    cyc++;
    hist.push_front(key_n);
    void'(hist.pop_back());
    exp_level   = m_pressed;
    exp_hold    = (ph == 2);
    was_pressed = m_pressed;
    flip        = 1'b1;
    for (int i = 2; i < DB + 2; i++)
      if (hist[i] != m_pressed) flip = 1'b0;
    if (flip) m_pressed = ~m_pressed;
    pe = !was_pressed &&  m_pressed;
    re =  was_pressed && !m_pressed;
    case (ph)
      0: if (pe) begin ph = 1; t_press = cyc; end
      1: begin
        if (m_pressed && (cyc - t_press == LG)) begin
          sb.push_back('{3'b001, cyc + 1});
          ph = 2;
        end else if (re) begin
          ph    = 3;
          t_rel = cyc;
        end
      end
      2: if (re) ph = 0;
      3: begin
        if (pe) begin
          sb.push_back('{3'b010, cyc + 1});
          ph = 4;
        end else if (cyc - t_rel == GP) begin
          sb.push_back('{3'b100, cyc + 1});
          ph = 0;
        end
      end
      default: if (re) ph = 0;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp);
    end
  endtask

  // Monitor: level outputs every cycle, pulses popped from the scoreboard.
  initial begin
    logic [2:0] pulses;
    ev_t e;
    forever begin
      @(negedge clk);
      chk("key_level", key_level, exp_level);
      chk("long_hold", long_hold, exp_hold);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL missed_pulse kind=%b at cyc=%0d not seen", e.kind, e.cyc);
      end
      pulses = {short_press, double_press, long_press};
      if (pulses != 3'b000) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse got=%b cyc=%0d expected none", pulses, cyc);
        end else begin
          e = sb.pop_front();
          if (e.kind !== pulses || e.cyc != cyc) begin
            bad++;
            $display("FAIL pulse got=%b@%0d exp=%b@%0d", pulses, cyc, e.kind, e.cyc);
          end
        end
      end
    end
  end

  task automatic hold(input logic k, input int n);
    key_n = k;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with the key pressed, then released.
    key_n = 1'b0;
    rst   = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    hold(1'b0, 12);
    hold(1'b1, 30);
    // Bounce.
    for (int i = 0; i < 5; i++) begin
      hold(1'b0, 3);
      hold(1'b1, 3);
    end
    hold(1'b1, 20);
    // Short press.
    hold(1'b0, 8);
    hold(1'b1, 30);
    // Double press.
    hold(1'b0, 8);
    hold(1'b1, 6);
    hold(1'b0, 8);
    hold(1'b1, 30);
    // Triple press.
    hold(1'b0, 8);
    hold(1'b1, 6);
    hold(1'b0, 8);
    hold(1'b1, 6);
    hold(1'b0, 8);
    hold(1'b1, 30);
    // Long press.
    hold(1'b0, 40);
    hold(1'b1, 30);
    // Reset while in the gap window.
    hold(1'b0, 8);
    hold(1'b1, 8);
    rst = 1'b0;
    hold(1'b1, 3);
    rst = 1'b1;
    hold(1'b1, 10);
    hold(1'b0, 8);
    hold(1'b1, 30);
    // Randomised segments.
    for (int i = 0; i < 150; i++) begin
      hold(1'(i % 2), $urandom_range(1, 25));
    end
    hold(1'b1, 50);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
